// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// default latencies and the unit's control states.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at start and held pending; only the commit is delayed.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic [31:0] md_A,
    input  logic [31:0] md_B,
    output logic        md_busy,
    output logic [31:0] md_HI,
    output logic [31:0] md_LO,
    output logic [31:0] md_rd
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi_q, lo_q, hi_next, lo_next;
    logic [31:0]      p_hi, p_lo, p_hi_next, p_lo_next;
    logic             p_valid, p_valid_next;

    logic [63:0] prod_s, prod_u;
    logic        op_signed, a_neg, b_neg;
    logic [31:0] div_a, div_b, div_b_safe, uq, ur, quot, rem;
    logic [31:0] res_hi, res_lo;

    assign prod_s = $signed({{32{md_A[31]}}, md_A}) * $signed({{32{md_B[31]}}, md_B});
    assign prod_u = {32'd0, md_A} * {32'd0, md_B};

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        op_signed  = (md_op == MD_DIV);
        a_neg      = op_signed && md_A[31];
        b_neg      = op_signed && md_B[31];
        div_a      = a_neg ? (32'd0 - md_A) : md_A;
        div_b      = b_neg ? (32'd0 - md_B) : md_B;
        div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
        uq         = div_a / div_b_safe;
        ur         = div_a % div_b_safe;
        quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem        = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (md_op == MD_MULT) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (md_op == MD_MULTU) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end else if (is_div(md_op)) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        hi_next      = hi_q;
        lo_next      = lo_q;
        p_hi_next    = p_hi;
        p_lo_next    = p_lo;
        p_valid_next = p_valid;
        unique case (state)
            ST_IDLE: begin
                if (md_start && is_arith(md_op)) begin
                    p_hi_next    = res_hi;
                    p_lo_next    = res_lo;
                    // A zero divisor still occupies the unit but leaves HI/LO untouched.
                    p_valid_next = !(is_div(md_op) && (md_B == 32'd0));
                    cnt_next     = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_next   = ST_BUSY;
                end else if (!md_start) begin
                    if (md_op == MD_MTHI) hi_next = md_A;
                    if (md_op == MD_MTLO) lo_next = md_A;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                    p_valid_next = 1'b0;
                    if (p_valid) begin
                        hi_next = p_hi;
                        lo_next = p_lo;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            p_valid <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            hi_q    <= hi_next;
            lo_q    <= lo_next;
            p_hi    <= p_hi_next;
            p_lo    <= p_lo_next;
            p_valid <= p_valid_next;
        end
    end

    assign md_busy = (state == ST_BUSY);
    assign md_HI   = hi_q;
    assign md_LO   = lo_q;

    // mfhi/mflo see committed values only; the hazard unit stalls them while busy.
    always_comb begin
        md_rd = 32'd0;
        if (md_op == MD_MFHI)      md_rd = hi_q;
        else if (md_op == MD_MFLO) md_rd = lo_q;
    end

    start_while_busy: assert property (@(posedge clk) disable iff (reset) !(md_start && md_busy))
        else $warning("md_start ignored while md_busy is high");

endmodule
